ram_sp_param: RTL and testbench
===============================

// Module: ram_sp_param
// PURPOSE
//   Parametrised single-port synchronous RAM with a valid/ready request port,
//   registered read response, bit-masked writes and a sequential hardware clear.
//   The clear zeroes one word per cycle: after reset, or on clr_start.
//   It is the CPU's data/scratch memory and is generalised in width and depth.
//   No multi-word clear logic exists in a single cycle.
// PARAMETERS
//   DATA_W   8   word width in bits (>=1)
//   ADDR_W   4   address width; DEPTH = 2**ADDR_W words
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset
//   clr_start  in   1        request a full memory clear (sampled in IDLE only)
//   req_valid  in   1        access request present
//   req_ready  out  1        request accepted when req_valid & req_ready
//   req_we     in   1        1 = write, 0 = read
//   req_addr   in   ADDR_W   word address
//   req_wdata  in   DATA_W   write data
//   req_wmask  in   DATA_W   per-bit write enable (1 = update bit)
//   rsp_valid  out  1        one-cycle pulse: rsp_rdata valid
//   rsp_rdata  out  DATA_W   read data (holds last value between reads)
//   busy       out  1        1 while clear sweep in progress
//   clr_done   out  1        one-cycle pulse after the last word is cleared
// BEHAVIOUR
// - States: CLEAR, IDLE. clr_ptr is an ADDR_W-bit sweep counter.
// - Reset (reset==0 at posedge):
//   - state=CLEAR, clr_ptr=0, rsp_valid=0, rsp_rdata=0, clr_done=0.
//   - Memory is not written during reset.
// - CLEAR, each posedge with reset==1:
//   - mem[clr_ptr] <= 0; clr_ptr++.
//   - When clr_ptr==DEPTH-1: state->IDLE, clr_done<=1 (next cycle only), clr_ptr->0.
//   - The sweep takes exactly DEPTH cycles.
//   - clr_start and req_valid are ignored; no request is accepted.
// - busy = (state==CLEAR), combinational.
// - req_ready = (state==IDLE) & ~clr_start, combinational.
// - clr_start in IDLE: next state is CLEAR with clr_ptr=0.
//   - It takes priority over a same-cycle request; that request is not accepted.
// - Accepted write: mem[a] <= (mem[a] & ~req_wmask) | (req_wdata & req_wmask).
//   - Writes produce no response; rsp_valid stays 0.
// - Accepted read at edge N:
//   - rsp_valid=1 and rsp_rdata=mem[addr] after edge N.
//   - Latency 1; back-to-back reads give one response per cycle.
// - Write then read of the same address on the next cycle returns the new data.
// - rsp_valid=0 in every cycle with no accepted read in the previous cycle.
// - Reset during CLEAR restarts the sweep from word 0.
//   - Reset during IDLE discards any in-flight read response (rsp_valid=0).
// - clr_done is never high while state==CLEAR.
//   - A new clr_start in the clr_done cycle is legal and starts a new sweep.
// TESTING
// - Reset low 3 cycles, then high:
//   - busy=1 for exactly 16 cycles (default), then clr_done pulses once
//     and req_ready=1.
//   - Reads of addr 0..15 give 0x00.
// - Write addr 4 = 0xA5 (mask 0xFF); read addr 4 next cycle:
//   - rsp_valid=1 exactly 1 cycle after acceptance; rsp_rdata=0xA5.
// - Masked write to addr 4 (prior value 0xA5), wdata 0x0F, mask 0xF0:
//   - Read returns 0x05.
//   - A following full-mask write of 0x3C reads back 0x3C.
// - Back-to-back reads of addr 1,2,3 (preloaded 0x11,0x22,0x33):
//   - rsp_valid high 3 consecutive cycles, data 0x11,0x22,0x33.
// - clr_start together with a write in IDLE:
//   - req_ready=0 and the write is dropped.
//   - 16-cycle sweep, then all words read 0.
// - Reset pulsed at sweep word 7:
//   - Sweep restarts; clr_done arrives 16 cycles after reset release.
//   - With DATA_W=16, ADDR_W=6: 64-cycle sweep.

Source files
------------

// File: rtl/ram_sp_param.sv
// ram_sp_param
//   Parametrised single-port synchronous RAM used as the CPU data/scratch
//   memory. It accepts requests over a valid/ready port, returns read data
//   one cycle after acceptance, supports per-bit masked writes, and runs a
//   sequential hardware clear. The clear zeroes one word per cycle and runs
//   after reset or when clr_start is seen while idle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clr_start  request a full memory clear (sampled in IDLE only)
//   req_valid  access request present
//   req_ready  request accepted when req_valid & req_ready
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_wmask  per-bit write enable (1 = update bit)
//   rsp_valid  one-cycle pulse, rsp_rdata valid
//   rsp_rdata  read data, holds last value between reads
//   busy       high while the clear sweep is in progress
//   clr_done   one-cycle pulse after the last word is cleared
module ram_sp_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
  logic              clr_done_reg, clr_done_next;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              req_fire;
  logic              rd_fire;
  logic              wr_fire;

  logic [DATA_W-1:0] mem [DEPTH];

  assign busy      = (state_reg == ST_CLEAR);
  // clr_start wins over a same-cycle request, so the port is not ready then.
  assign req_ready = (state_reg == ST_IDLE) & ~clr_start;
  assign req_fire  = req_valid & req_ready;
  assign rd_fire   = req_fire & ~req_we;
  assign wr_fire   = req_fire & req_we;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign clr_done  = clr_done_reg;

  // Next-state logic for the clear sweep.
  always_comb begin
    state_next    = state_reg;
    clr_ptr_next  = clr_ptr_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        // The pointer wraps to zero naturally after the last word.
        clr_ptr_next = clr_ptr_reg + ADDR_W'(1);
        if (&clr_ptr_reg) begin
          state_next    = ST_IDLE;
          clr_done_next = 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_next   = ST_CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_CLEAR;
      clr_ptr_reg  <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // Single write port shared by the sweep and accepted writes; the two never
  // coincide because requests are refused while clearing. Bit-enable writes
  // avoid a read-modify-write path through the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_reg == ST_CLEAR) begin
        mem[clr_ptr_reg] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (req_wmask[i]) begin
            mem[req_addr][i] <= req_wdata[i];
          end
        end
      end
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= rd_fire;
      if (rd_fire) begin
        rsp_rdata_reg <= mem[req_addr];
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// tb_ram_sp_param
//   Self-checking bench for ram_sp_param. A default-size instance is
//   exercised with directed scenarios and random traffic checked against an
//   array model; a 16x64 instance checks the sweep length.
module tb_ram_sp_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_start;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_wmask;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       clr_done;

  logic        w_clr_start = 1'b0;
  logic        w_req_valid = 1'b0;
  logic        w_req_ready;
  logic        w_req_we    = 1'b0;
  logic [5:0]  w_req_addr  = '0;
  logic [15:0] w_req_wdata = '0;
  logic [15:0] w_req_wmask = '0;
  logic        w_rsp_valid;
  logic [15:0] w_rsp_rdata;
  logic        w_busy;
  logic        w_clr_done;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] model [16];

  always #5 clk = ~clk;

  ram_sp_param dut (
    .clk(clk), .reset(reset), .clr_start(clr_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .clr_done(clr_done)
  );

  ram_sp_param #(.DATA_W(16), .ADDR_W(6)) dut_wide (
    .clk(clk), .reset(reset), .clr_start(w_clr_start),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_wmask(w_req_wmask),
    .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata),
    .busy(w_busy), .clr_done(w_clr_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  // Issue one write; the model applies the mask rule.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    step();
    idle_inputs();
    model[a] = (model[a] & ~m) | (d & m);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
  endtask

  task automatic test_reset();
    int cnt1, cnt2, done1, done2, ndone1, overlap;
    logic rdy16;
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();
    n_vec++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || clr_done !== 1'b0 || rsp_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rsp_valid=%b clr_done=%b rdata=%h, want 1 0 0 00",
               busy, rsp_valid, clr_done, rsp_rdata);
    end
    reset = 1'b1;
    cnt1 = 0; cnt2 = 0; done1 = -1; done2 = -1; ndone1 = 0; overlap = 0; rdy16 = 1'b0;
    for (int t = 0; t < 70; t++) begin
      if (busy) cnt1++;
      if (w_busy) cnt2++;
      if (clr_done) begin
        ndone1++;
        if (done1 < 0) done1 = t;
        if (busy) overlap++;
      end
      if (w_clr_done && done2 < 0) done2 = t;
      if (t == 16) rdy16 = req_ready;
      step();
    end
    n_vec++;
    if (cnt1 != 16 || done1 != 16 || ndone1 != 1 || overlap != 0) begin
      n_fail++;
      $display("FAIL sweep_16: busy_cycles=%0d done_at=%0d pulses=%0d overlap=%0d, want 16 16 1 0",
               cnt1, done1, ndone1, overlap);
    end
    n_vec++;
    if (rdy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_sweep: req_ready=%b, want 1", rdy16);
    end
    n_vec++;
    if (cnt2 != 64 || done2 != 64) begin
      n_fail++;
      $display("FAIL sweep_64: busy_cycles=%0d done_at=%0d, want 64 64", cnt2, done2);
    end
    clear_model();
    for (int a = 0; a < 16; a++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(a);
      step();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL cleared_read a=%0d: valid=%b data=%h, want 1 00", a, rsp_valid, rsp_rdata);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_read();
    do_write(4'd4, 8'hA5, 8'hFF);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_rsp: rsp_valid=%b, want 0", rsp_valid);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    step();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_read: valid=%b data=%h, want 1 a5", rsp_valid, rsp_rdata);
    end
    step();
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL rsp_pulse_hold: valid=%b data=%h, want 0 a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_masked_write();
    do_write(4'd4, 8'h0F, 8'hF0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    step();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h05) begin
      n_fail++;
      $display("FAIL masked_write: valid=%b data=%h, want 1 05", rsp_valid, rsp_rdata);
    end
    do_write(4'd4, 8'h3C, 8'hFF);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    step();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL full_write: valid=%b data=%h, want 1 3c", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expv [3];
    expv[0] = 8'h11; expv[1] = 8'h22; expv[2] = 8'h33;
    for (int i = 0; i < 3; i++) do_write(4'(i + 1), expv[i], 8'hFF);
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(i + 1);
      step();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== expv[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: valid=%b data=%h, want 1 %h", i, rsp_valid, rsp_rdata, expv[i]);
      end
    end
    idle_inputs();
    step();
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_clr_collision();
    int cnt, done_at;
    do_write(4'd9, 8'h77, 8'hFF);
    clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9;
    req_wdata = 8'hFF; req_wmask = 8'hFF;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_priority_ready: req_ready=%b, want 0", req_ready);
    end
    step();
    idle_inputs();
    cnt = 0; done_at = -1;
    for (int t = 0; t < 40; t++) begin
      if (busy) cnt++;
      if (clr_done && done_at < 0) done_at = t;
      step();
    end
    n_vec++;
    if (cnt != 16 || done_at != 16) begin
      n_fail++;
      $display("FAIL clr_sweep: busy_cycles=%0d done_at=%0d, want 16 16", cnt, done_at);
    end
    clear_model();
    for (int a = 0; a < 16; a++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(a);
      step();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL clr_read a=%0d: valid=%b data=%h, want 1 00", a, rsp_valid, rsp_rdata);
      end
    end
    idle_inputs();
    step();
  endtask

  // Random reads/writes against the array model; the expected response for
  // the current cycle comes from the operation issued in the previous cycle.
  task automatic test_random();
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] last_data;
    int         op;
    logic [3:0] a;
    logic [7:0] d, m;
    exp_valid = 1'b0;
    last_data = rsp_rdata;
    exp_data  = last_data;
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 2));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      m  = 8'($urandom);
      idle_inputs();
      if (op == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      end else if (op == 2) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      end
      step();
      if (op == 2) begin
        exp_valid = 1'b1;
        exp_data  = model[a];
        last_data = model[a];
      end else begin
        exp_valid = 1'b0;
        exp_data  = last_data;
      end
      if (op == 1) model[a] = (model[a] & ~m) | (d & m);
      n_vec++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_data) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%0d: valid=%b data=%h, want %b %h",
                 n, op, a, rsp_valid, rsp_rdata, exp_valid, exp_data);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_idle_read();
    int guard;
    do_write(4'd2, 8'h99, 8'hFF);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    reset = 1'b0;
    step();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_discards_read: valid=%b data=%h, want 0 00", rsp_valid, rsp_rdata);
    end
    reset = 1'b1;
    guard = 0;
    while (!clr_done && guard < 100) begin
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL reset_idle_timeout: clr_done=%b after %0d cycles, want 1", clr_done, guard);
    end
    clear_model();
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int cnt, done_at;
    do_write(4'd12, 8'h5A, 8'hFF);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (7) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    cnt = 0; done_at = -1;
    for (int t = 0; t < 30; t++) begin
      if (busy) cnt++;
      if (clr_done && done_at < 0) done_at = t;
      step();
    end
    n_vec++;
    if (cnt != 16 || done_at != 16) begin
      n_fail++;
      $display("FAIL mid_sweep_reset: busy_cycles=%0d done_at=%0d, want 16 16", cnt, done_at);
    end
    clear_model();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd12;
    step();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model[12]) begin
      n_fail++;
      $display("FAIL mid_sweep_read: valid=%b data=%h, want 1 %h", rsp_valid, rsp_rdata, model[12]);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    clear_model();
    test_reset();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_clr_collision();
    test_random();
    test_reset_idle_read();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
